// File: rtl/row_render_seq.sv
// rtl/row_render_seq.sv - row renderer: span test, bit-serial v-step divider, texture DDA and shading
// Optional macro ROW_RENDER_SEQ_CLIP_EN: pre-steps v so walls taller than the view start clipped.
module row_render_seq #(
    parameter int H_VIEW     = 640,
    parameter int HPOS_W     = 10,
    parameter int SIZE_W     = 11,
    parameter int TEX_BITS   = 6,
    parameter int WALL_BITS  = 2,
    parameter int COLOR_BITS = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            load,
    input  logic [WALL_BITS-1:0]            wall,
    input  logic                            side,
    input  logic [SIZE_W-1:0]               size,
    input  logic [TEX_BITS-1:0]             texu,
    output logic                            busy,
    input  logic                            pix_en,
    input  logic [HPOS_W-1:0]               hpos,
    output logic [WALL_BITS+2*TEX_BITS-1:0] tex_addr,
    input  logic [3*COLOR_BITS-1:0]         tex_data,
    output logic [3*COLOR_BITS-1:0]         rgb,
    output logic                            hit,
    output logic [TEX_BITS-1:0]             texv
);
    localparam int HALF  = H_VIEW / 2;
    localparam int W     = SIZE_W + TEX_BITS + 1;
    localparam int DW    = SIZE_W + 1;
    localparam int RW    = SIZE_W + 2;
    localparam int AW    = TEX_BITS + 1;
    localparam int TAW   = WALL_BITS + 2 * TEX_BITS;
    localparam int CW    = 3 * COLOR_BITS;
    localparam int CNT_W = $clog2(W);
    localparam logic [W-1:0] STEP_DVD = W'(1) << TEX_BITS;

    typedef enum logic [1:0] {IDLE, DIV_STEP, DIV_PRE, READY} state_t;

    state_t               state_q, state_d;
    logic [WALL_BITS-1:0] wall_q;
    logic                 side_q;
    logic [SIZE_W-1:0]    size_q;
    logic [TEX_BITS-1:0]  texu_q;
    logic [W-1:0]         dvd_q, dvd_d;
    logic [DW-1:0]        rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]        qs_q, qs_d, acc_q, acc_d;
    logic [DW-1:0]        rs_q, rs_d, frac_q, frac_d;

    logic [TAW-1:0]       tex_addr_q;
    logic                 hit1_q, side1_q, hit_q;
    logic [TEX_BITS-1:0]  texv1_q, texv_q;
    logic [CW-1:0]        rgb_q, shaded;

    logic [RW-1:0]        dvs_ext, trial, frac_sum;
    logic                 ge, carry, div_last, in_span, pix_hit;
    logic [AW:0]          acc_sum;
    logic [TEX_BITS-1:0]  texv_now;
    logic signed [RW-1:0] s_size, s_hpos, span_lo, span_hi;

    // One restoring step: dividend bits shift out the top, quotient bits shift in below.
    assign dvs_ext  = {1'b0, size_q, 1'b0};
    assign trial    = {rem_q, dvd_q[W-1]};
    assign ge       = trial >= dvs_ext;
    assign div_last = cnt_q == CNT_W'(W - 1);

    assign frac_sum = {1'b0, frac_q} + {1'b0, rs_q};
    assign carry    = frac_sum >= dvs_ext;
    assign acc_sum  = {1'b0, acc_q} + {1'b0, qs_q} + {{AW{1'b0}}, carry};
    assign texv_now = acc_q[AW-1] ? {TEX_BITS{1'b1}} : acc_q[TEX_BITS-1:0];

    // A zero-height wall has no span at all, not a one-pixel sliver at the centre.
    assign s_size  = $signed(RW'(size_q));
    assign s_hpos  = $signed(RW'(hpos));
    assign span_lo = $signed(RW'(HALF)) - s_size;
    assign span_hi = $signed(RW'(HALF)) + s_size;
    assign in_span = (size_q != '0) &&
                     ((size_q > SIZE_W'(HALF)) || ((s_hpos >= span_lo) && (s_hpos <= span_hi)));
    assign pix_hit = (state_q == READY) && pix_en && in_span;

`ifdef ROW_RENDER_SEQ_CLIP_EN
    logic [SIZE_W-1:0] clip_k;
    assign clip_k = size_q - SIZE_W'(HALF);
`endif

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        qs_d    = qs_q;
        rs_d    = rs_q;
        acc_d   = acc_q;
        frac_d  = frac_q;
        case (state_q)
            DIV_STEP: begin
                dvd_d = {dvd_q[W-2:0], ge};
                rem_d = ge ? DW'(trial - dvs_ext) : DW'(trial);
                cnt_d = cnt_q + CNT_W'(1);
                if (div_last) begin
                    qs_d    = AW'({dvd_q[W-2:0], ge});
                    rs_d    = ge ? DW'(trial - dvs_ext) : DW'(trial);
                    state_d = READY;
                    acc_d   = '0;
                    frac_d  = '0;
`ifdef ROW_RENDER_SEQ_CLIP_EN
                    if (size_q > SIZE_W'(HALF)) begin
                        state_d = DIV_PRE;
                        dvd_d   = {1'b0, clip_k, {TEX_BITS{1'b0}}};
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
`endif
                end
            end
`ifdef ROW_RENDER_SEQ_CLIP_EN
            DIV_PRE: begin
                dvd_d = {dvd_q[W-2:0], ge};
                rem_d = ge ? DW'(trial - dvs_ext) : DW'(trial);
                cnt_d = cnt_q + CNT_W'(1);
                if (div_last) begin
                    acc_d   = AW'({dvd_q[W-2:0], ge});
                    frac_d  = ge ? DW'(trial - dvs_ext) : DW'(trial);
                    state_d = READY;
                end
            end
`endif
            READY: begin
                if (pix_hit) begin
                    frac_d = carry ? DW'(frac_sum - dvs_ext) : DW'(frac_sum);
                    acc_d  = acc_sum[AW] ? {AW{1'b1}} : acc_sum[AW-1:0];
                end
            end
            default: ;
        endcase
        if (load) begin
            state_d = (size == '0) ? READY : DIV_STEP;
            dvd_d   = STEP_DVD;
            rem_d   = '0;
            cnt_d   = '0;
            acc_d   = '0;
            frac_d  = '0;
        end
    end

    always_comb begin
        shaded = '0;
        for (int c = 0; c < 3; c++) begin
            shaded[c*COLOR_BITS +: COLOR_BITS] = side1_q ? tex_data[c*COLOR_BITS +: COLOR_BITS]
                                                         : tex_data[c*COLOR_BITS +: COLOR_BITS] >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wall_q     <= '0;
            side_q     <= 1'b0;
            size_q     <= '0;
            texu_q     <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            qs_q       <= '0;
            rs_q       <= '0;
            acc_q      <= '0;
            frac_q     <= '0;
            tex_addr_q <= '0;
            hit1_q     <= 1'b0;
            side1_q    <= 1'b0;
            texv1_q    <= '0;
            hit_q      <= 1'b0;
            texv_q     <= '0;
            rgb_q      <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qs_q    <= qs_d;
            rs_q    <= rs_d;
            acc_q   <= acc_d;
            frac_q  <= frac_d;
            if (load) begin
                wall_q <= wall;
                side_q <= side;
                size_q <= size;
                texu_q <= texu;
            end
            // Pixel pipeline: address stage, then shade stage fed by the ROM texel.
            if (pix_en) begin
                tex_addr_q <= {wall_q, texu_q, pix_hit ? texv_now : {TEX_BITS{1'b0}}};
            end
            hit1_q  <= pix_hit;
            side1_q <= side_q;
            texv1_q <= pix_hit ? texv_now : '0;
            hit_q   <= hit1_q;
            texv_q  <= texv1_q;
            rgb_q   <= hit1_q ? shaded : '0;
        end
    end

    assign busy     = (state_q == DIV_STEP) || (state_q == DIV_PRE);
    assign tex_addr = tex_addr_q;
    assign hit      = hit_q;
    assign texv     = texv_q;
    assign rgb      = rgb_q;

endmodule

// File: tb/tb_row_render_seq.sv
// tb/tb_row_render_seq.sv - self-checking bench for row_render_seq against an arithmetic row model
module tb_row_render_seq;
    localparam int H_VIEW     = 640;
    localparam int HPOS_W     = 10;
    localparam int SIZE_W     = 11;
    localparam int TEX_BITS   = 6;
    localparam int WALL_BITS  = 2;
    localparam int COLOR_BITS = 2;
    localparam int HALF       = H_VIEW / 2;
    localparam int W          = SIZE_W + TEX_BITS + 1;
    localparam int AW         = WALL_BITS + 2 * TEX_BITS;
    localparam int CW         = 3 * COLOR_BITS;
`ifdef ROW_RENDER_SEQ_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 load = 1'b0;
    logic [WALL_BITS-1:0] wall = '0;
    logic                 side = 1'b0;
    logic [SIZE_W-1:0]    size = '0;
    logic [TEX_BITS-1:0]  texu = '0;
    logic                 busy;
    logic                 pix_en = 1'b0;
    logic [HPOS_W-1:0]    hpos = '0;
    logic [AW-1:0]        tex_addr;
    logic [CW-1:0]        tex_data;
    logic [CW-1:0]        rgb;
    logic                 hit;
    logic [TEX_BITS-1:0]  texv;
    logic                 force_en = 1'b0;
    logic [CW-1:0]        force_val = '0;

    row_render_seq #(
        .H_VIEW(H_VIEW), .HPOS_W(HPOS_W), .SIZE_W(SIZE_W),
        .TEX_BITS(TEX_BITS), .WALL_BITS(WALL_BITS), .COLOR_BITS(COLOR_BITS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .wall(wall), .side(side),
        .size(size), .texu(texu), .busy(busy), .pix_en(pix_en), .hpos(hpos),
        .tex_addr(tex_addr), .tex_data(tex_data), .rgb(rgb), .hit(hit), .texv(texv)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] rom(input logic [AW-1:0] a);
        return a[CW-1:0] ^ a[2*TEX_BITS-1:TEX_BITS] ^ {3{a[AW-1:AW-2]}};
    endfunction

    assign tex_data = force_en ? force_val : rom(tex_addr);

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic                hit;
        logic [TEX_BITS-1:0] texv;
        logic [AW-1:0]       addr;
        logic [CW-1:0]       rgb;
        logic [HPOS_W-1:0]   hpos;
    } pix_t;

    bit   m_loaded;
    int   m_size, m_wall, m_texu, m_j, m_bl, m_n;
    bit   m_side;
    pix_t p1;
    int   bcount, hit_cnt, hit_min, hit_max;
    int   rec_texv [0:(1<<HPOS_W)-1];

    function automatic int busy_len(input int sz);
        if (sz == 0) return 0;
        return (CLIP && sz > HALF) ? 2 * W : W;
    endfunction

    function automatic bit in_span(input int sz, input int hp);
        if (sz == 0) return 1'b0;
        if (sz > HALF) return 1'b1;
        return (hp >= HALF - sz) && (hp <= HALF + sz);
    endfunction

    // v of the n-th in-span pixel: floor((k + n) * 2^T / (2*size)), clamped to the texture.
    function automatic int exp_v(input int sz, input int n);
        int base, v;
        base = (CLIP && sz > HALF) ? sz - HALF : 0;
        v = ((base + n) * (1 << TEX_BITS)) / (2 * sz);
        return (v > (1 << TEX_BITS) - 1) ? (1 << TEX_BITS) - 1 : v;
    endfunction

    function automatic logic [CW-1:0] shade(input logic [CW-1:0] c, input bit s);
        int r, ch;
        r = 0;
        for (int i = 0; i < 3; i++) begin
            ch = (int'(c) >> (i * COLOR_BITS)) % (1 << COLOR_BITS);
            if (!s) ch = ch / 2;
            r += ch << (i * COLOR_BITS);
        end
        return CW'(r);
    endfunction

    task automatic reset_model();
        m_loaded = 1'b0;
        m_size = 0; m_wall = 0; m_texu = 0; m_side = 1'b0;
        m_j = 0; m_bl = 0; m_n = 0;
        p1 = '0;
        bcount = 0;
    endtask

    task automatic clear_rec();
        hit_cnt = 0;
        hit_min = 1 << 30;
        hit_max = -1;
        for (int i = 0; i < (1 << HPOS_W); i++) rec_texv[i] = -1;
    endtask

    // One clock: predict the pixel driven now, advance, then compare at the falling edge.
    task automatic tick();
        pix_t np;
        bit   ready;
        int   v;
        np = '0;
        np.hpos = hpos;
        ready = m_loaded && (m_j >= m_bl);
        if (pix_en && ready && in_span(m_size, int'(hpos))) begin
            v = exp_v(m_size, m_n);
            np.hit  = 1'b1;
            np.texv = TEX_BITS'(v);
            np.addr = {WALL_BITS'(m_wall), TEX_BITS'(m_texu), TEX_BITS'(v)};
            np.rgb  = shade(force_en ? force_val : rom(np.addr), m_side);
            m_n++;
        end
        if (load) begin
            m_loaded = 1'b1;
            m_size = int'(size); m_side = side; m_wall = int'(wall); m_texu = int'(texu);
            m_j = 0; m_n = 0; m_bl = busy_len(m_size);
            bcount = 0;
        end else if (m_j < 1000000) begin
            m_j++;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("busy", busy, m_loaded && (m_j < m_bl));
        if (busy) bcount++;
        if (np.hit) check_eq("tex_addr", tex_addr, np.addr);
        check_eq("hit", hit, p1.hit);
        check_eq("rgb", rgb, p1.rgb);
        if (p1.hit) check_eq("texv", texv, p1.texv);
        if (hit) begin
            hit_cnt++;
            rec_texv[p1.hpos] = int'(texv);
            if (int'(p1.hpos) < hit_min) hit_min = int'(p1.hpos);
            if (int'(p1.hpos) > hit_max) hit_max = int'(p1.hpos);
        end
        p1 = np;
    endtask

    task automatic start_row(input int sz, input bit sd, input int wl, input int tu);
        load = 1'b1;
        size = SIZE_W'(sz);
        side = sd;
        wall = WALL_BITS'(wl);
        texu = TEX_BITS'(tu);
        tick();
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic sweep();
        for (int h = 0; h < H_VIEW; h++) begin
            pix_en = 1'b1;
            hpos = HPOS_W'(h);
            tick();
        end
        pix_en = 1'b0;
    endtask

    initial begin
        reset_model();
        clear_rec();
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_hit", hit, 0);
        check_eq("rst_rgb", rgb, 0);
        check_eq("rst_texv", texv, 0);
        check_eq("rst_addr", tex_addr, 0);
        reset_n = 1'b1;
        idle(2);

        // In-view wall
        start_row(160, 1'b1, 2, 37);
        idle(22);
        check_eq("iv_busy_len", bcount, 18);
        clear_rec();
        sweep();
        idle(3);
        check_eq("iv_hits", hit_cnt, 321);
        check_eq("iv_first", hit_min, 160);
        check_eq("iv_last", hit_max, 480);
        check_eq("iv_texv160", rec_texv[160], 0);
        check_eq("iv_texv320", rec_texv[320], 32);
        check_eq("iv_texv480", rec_texv[480], 63);

        // Asynchronous reset in the middle of a division
        start_row(100, 1'b1, 3, 21);
        idle(5);
        #1 reset_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_hit", hit, 0);
        check_eq("arst_rgb", rgb, 0);
        check_eq("arst_addr", tex_addr, 0);
        reset_model();
        @(negedge clk);
        reset_n = 1'b1;
        pix_en = 1'b1;
        hpos = HPOS_W'(HALF);
        repeat (3) tick();
        idle(2);

        // Zero-size wall
        start_row(0, 1'b1, 1, 5);
        idle(3);
        clear_rec();
        sweep();
        idle(3);
        check_eq("zero_busy", bcount, 0);
        check_eq("zero_hits", hit_cnt, 0);

        // Wall taller than the view
        start_row(640, 1'b1, 3, 9);
        idle(40);
        check_eq("clip_busy_len", bcount, CLIP ? 36 : 18);
        clear_rec();
        sweep();
        idle(3);
        check_eq("clip_hits", hit_cnt, 640);
        check_eq("clip_texv0", rec_texv[0], CLIP ? 16 : 0);
        check_eq("clip_texv639", rec_texv[639], CLIP ? 47 : 31);

        // Shading and two-cycle latency
        force_en = 1'b1;
        force_val = 6'b11_10_01;
        for (int s = 0; s < 2; s++) begin
            start_row(300, s[0], 1, 1);
            idle(20);
            pix_en = 1'b1;
            hpos = HPOS_W'(HALF);
            tick();
            pix_en = 1'b0;
            tick();
            check_eq(s == 0 ? "shade_dark" : "shade_light", rgb, s == 0 ? 6'b01_01_00 : 6'b11_10_01);
            check_eq("shade_hit", hit, 1);
            tick();
            check_eq("hit_drop", hit, 0);
        end
        force_en = 1'b0;

        // Abort: a second load restarts the division
        pix_en = 1'b1;
        hpos = HPOS_W'(HALF);
        start_row(50, 1'b1, 2, 3);
        repeat (4) tick();
        clear_rec();
        start_row(200, 1'b0, 1, 44);
        repeat (17) tick();
        idle(2);
        check_eq("abort_busy_len", bcount, 18);
        check_eq("abort_busy_hits", hit_cnt, 0);
        clear_rec();
        sweep();
        idle(3);
        check_eq("abort_hits", hit_cnt, 401);
        check_eq("abort_first", hit_min, 120);
        check_eq("abort_last", hit_max, 520);

        // Randomized rows, random strobes and occasional mid-row reloads
        for (int r = 0; r < 16; r++) begin
            int sz;
            case ($urandom % 6)
                0:       sz = 0;
                1:       sz = int'($urandom_range(1, HALF));
                2:       sz = HALF - 1 + int'($urandom_range(0, 2));
                3:       sz = int'($urandom_range(HALF + 1, (1 << SIZE_W) - 1));
                4:       sz = 1;
                default: sz = int'($urandom_range(1, (1 << SIZE_W) - 1));
            endcase
            pix_en = ($urandom % 2) == 0;
            hpos = HPOS_W'($urandom_range(0, H_VIEW - 1));
            start_row(sz, 1'($urandom), int'($urandom % 4), int'($urandom % 64));
            for (int c = 0; c < int'($urandom_range(60, 180)); c++) begin
                pix_en = ($urandom % 4) != 0;
                hpos = HPOS_W'($urandom_range(0, H_VIEW - 1));
                if (($urandom % 50) == 0) begin
                    start_row(int'($urandom_range(0, (1 << SIZE_W) - 1)), 1'($urandom),
                              int'($urandom % 4), int'($urandom % 64));
                end else begin
                    tick();
                end
            end
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
